// File: rtl/reg_viewer_pkg.sv
// Shared constants and the hex-to-seven-segment glyph lookup for the register viewer.
package reg_viewer_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_REGS   = 32;
    localparam int SEL_W      = $clog2(NUM_REGS);

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex7(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/reg_viewer_if.sv
// Register-debug port of the computer plus the multiplexed display lines.
interface reg_viewer_if;
    import reg_viewer_pkg::*;

    logic [SEL_W-1:0]      reg_sel;
    logic [31:0]           reg_data;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            seg;

    // master: the viewer; slave: the computer/board side
    modport master (output reg_sel, an, seg, input reg_data);
    modport slave  (input reg_sel, an, seg, output reg_data);

endinterface

// File: rtl/reg_viewer_btn_debounce.sv
// Push-button synchronizer, stability debounce and rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1, sync2, level_q, armed;
    logic [CW-1:0] cnt;

    // Sync flops reset to "pressed" so a button held through reset is never
    // mistaken for released; presses are only accepted once the button has
    // been seen released for a full debounce window (armed).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            btn_level <= 1'b0;
            level_q   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            level_q <= btn_level;
            if (!armed) begin
                if (sync2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    armed <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (sync2 != btn_level) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    btn_level <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign btn_rise = btn_level & ~level_q;

endmodule

// File: rtl/reg_viewer.sv
// Register inspector: steps reg_sel by button or timer and shows reg_data in hex.
module reg_viewer
    import reg_viewer_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int STEP_DIV = 50000000,
    parameter int DEB_CYC  = 500000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_next,
    input  logic          auto_en,
    reg_viewer_if.master  bus
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int TW = $clog2(STEP_DIV + 1);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    logic                  btn_level, btn_rise;
    logic                  step_btn, step_auto, step, sel_chg;
    logic                  scan_wrap, frame_start;
    logic [TW-1:0]         auto_cnt;
    logic [SW-1:0]         scan_cnt;
    logic [DW-1:0]         dig;
    logic [SEL_W-1:0]      sel_q;
    logic [31:0]           shown;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            seg_q;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_next),
        .btn_level (btn_level),
        .btn_rise  (btn_rise)
    );

    // A rise always coincides with the level being high; qualifying keeps the
    // step tied to the accepted debounced state.
    assign step_btn    = btn_rise & btn_level;
    assign step_auto   = auto_en && (auto_cnt == STEP_LAST);
    assign step        = step_btn | step_auto;
    assign scan_wrap   = (scan_cnt == SCAN_LAST);
    assign frame_start = scan_wrap && (dig == DIG_LAST);

    // Auto-advance timer; any time auto_en is low the partial count is dropped.
    always_ff @(posedge clk) begin
        if (rst || !auto_en) auto_cnt <= '0;
        else if (step_auto)  auto_cnt <= '0;
        else                 auto_cnt <= auto_cnt + TW'(1);
    end

    // Register index; coincident button and timer steps merge into one.
    always_ff @(posedge clk) begin
        if (rst)       sel_q <= '0;
        else if (step) sel_q <= sel_q + SEL_W'(1);
    end

    // Snapshot reg_data one cycle after a select change, and at each frame start,
    // so a frame never shows a mix of two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_chg <= 1'b0;
            shown   <= '0;
        end else begin
            sel_chg <= step;
            if (sel_chg || frame_start) shown <= bus.reg_data;
        end
    end

    // Digit-slot timer and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig      <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            dig      <= dig + DW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Registered display drive for the current digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= ~(NUM_DIGITS'(1) << dig);
            seg_q <= hex7(shown[{dig, 2'b00} +: 4]);
        end
    end

    assign bus.reg_sel = sel_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;

endmodule

// File: tb/tb_reg_viewer.sv
// Self-checking bench for reg_viewer with a simple register-file model.
module tb_reg_viewer;

    localparam int SCAN_DIV  = 4;
    localparam int STEP_DIV  = 16;
    localparam int DEB_CYC   = 4;
    localparam int PRESS_LAT = 2 + DEB_CYC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic [31:0] data_base = 32'h1000_0000;
    int          checks = 0;
    int          failures = 0;
    int          model_sel = 0;
    logic [7:0]  glyph [16];
    logic [7:0]  an_cap [8];
    logic [7:0]  seg_cap [8];

    reg_viewer_if bus();
    assign bus.reg_data = data_base + 32'(bus.reg_sel);

    reg_viewer #(.SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int i);
        logic [3:0] n;
        n = 4'(v >> (4 * i));
        return glyph[n];
    endfunction

    function automatic logic [7:0] exp_an(input int i);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << i);
    endfunction

    // Samples the first cycle of each slot in [first, last].
    task automatic grab(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            an_cap[i]  = bus.an;
            seg_cap[i] = bus.seg;
            repeat (SCAN_DIV) @(negedge clk);
        end
    endtask

    // Waits for the first cycle of a frame (an becomes FE).
    task automatic sync_frame(output bit ok);
        logic [7:0] prev;
        prev = bus.an;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.an === 8'hFE && prev !== 8'hFE) begin
                ok = 1'b1;
                break;
            end
            prev = bus.an;
        end
    endtask

    task automatic do_press;
        btn_next = 1'b1;
        repeat (PRESS_LAT + 1) @(negedge clk);
        btn_next = 1'b0;
        repeat (PRESS_LAT + 1 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.reg_sel !== 5'd0) begin
                failures++;
                $display("FAIL reset_blank an=%h seg=%h sel=%0d expected FF FF 0", bus.an, bus.seg, bus.reg_sel);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.an !== 8'hFE || bus.seg !== 8'hC0) begin
            failures++;
            $display("FAIL first_after_reset an=%h seg=%h expected FE C0", bus.an, bus.seg);
        end
        grab(0, 7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (an_cap[i] !== exp_an(i) || seg_cap[i] !== 8'hC0) begin
                failures++;
                $display("FAIL reset_frame1 slot%0d an=%h seg=%h expected %h C0", i, an_cap[i], seg_cap[i], exp_an(i));
            end
        end
        grab(0, 7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (an_cap[i] !== exp_an(i) || seg_cap[i] !== exp_seg(32'h1000_0000, i)) begin
                failures++;
                $display("FAIL reset_frame2 slot%0d an=%h seg=%h expected %h %h", i, an_cap[i], seg_cap[i],
                         exp_an(i), exp_seg(32'h1000_0000, i));
            end
        end
    endtask

    task automatic test_debounce;
        int s0;
        s0 = model_sel;
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            btn_next = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            btn_next = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'(s0)) begin
                failures++;
                $display("FAIL glitch_ignored sel=%0d expected %0d", bus.reg_sel, s0);
            end
        end
        btn_next = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'((k >= PRESS_LAT) ? s0 + 1 : s0)) begin
                failures++;
                $display("FAIL press_latency k=%0d sel=%0d expected %0d", k, bus.reg_sel,
                         (k >= PRESS_LAT) ? s0 + 1 : s0);
            end
        end
        btn_next = 1'b0;
        model_sel = (s0 + 1) % 32;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'(model_sel)) begin
                failures++;
                $display("FAIL release_no_step sel=%0d expected %0d", bus.reg_sel, model_sel);
            end
        end
    endtask

    task automatic test_wrap;
        bit ok;
        for (int p = 0; p < 32; p++) begin
            do_press();
            model_sel = (model_sel + 1) % 32;
            checks++;
            if (bus.reg_sel !== 5'(model_sel)) begin
                failures++;
                $display("FAIL wrap_press%0d sel=%0d expected %0d", p, bus.reg_sel, model_sel);
            end
            if (model_sel == 31) begin
                sync_frame(ok);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL wrap_sync timeout got 0 expected 1");
                end
                grab(0, 7);
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (an_cap[i] !== exp_an(i) || seg_cap[i] !== exp_seg(32'h1000_001F, i)) begin
                        failures++;
                        $display("FAIL wrap_display slot%0d an=%h seg=%h expected %h %h", i, an_cap[i],
                                 seg_cap[i], exp_an(i), exp_seg(32'h1000_001F, i));
                    end
                end
            end
        end
    endtask

    task automatic test_auto;
        int s0;
        s0 = model_sel;
        auto_en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'((s0 + k / STEP_DIV) % 32)) begin
                failures++;
                $display("FAIL auto_step k=%0d sel=%0d expected %0d", k, bus.reg_sel, (s0 + k / STEP_DIV) % 32);
            end
            // Button accepted exactly on the fourth timer step.
            if (k == 4 * STEP_DIV - PRESS_LAT) btn_next = 1'b1;
        end
        btn_next = 1'b0;
        auto_en = 1'b0;
        model_sel = (s0 + 4) % 32;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'(model_sel)) begin
                failures++;
                $display("FAIL auto_off_hold sel=%0d expected %0d", bus.reg_sel, model_sel);
            end
        end
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        auto_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'((k >= STEP_DIV) ? (model_sel + 1) % 32 : model_sel)) begin
                failures++;
                $display("FAIL auto_discard k=%0d sel=%0d expected %0d", k, bus.reg_sel,
                         (k >= STEP_DIV) ? (model_sel + 1) % 32 : model_sel);
            end
        end
        auto_en = 1'b0;
        model_sel = (model_sel + 1) % 32;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_sel_settle;
        bit ok;
        logic [31:0] oldv, newv;
        sync_frame(ok);
        oldv = data_base + 32'(model_sel);
        data_base = $urandom;
        newv = data_base + 32'(model_sel + 1);
        btn_next = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (!ok || bus.reg_sel !== 5'((model_sel + 1) % 32) || bus.seg !== exp_seg(oldv, 2)) begin
            failures++;
            $display("FAIL settle_before sync=%0d sel=%0d seg=%h expected 1 %0d %h", ok, bus.reg_sel, bus.seg,
                     (model_sel + 1) % 32, exp_seg(oldv, 2));
        end
        @(negedge clk);
        checks++;
        if (bus.an !== exp_an(2) || bus.seg !== exp_seg(newv, 2)) begin
            failures++;
            $display("FAIL settle_after an=%h seg=%h expected %h %h", bus.an, bus.seg, exp_an(2), exp_seg(newv, 2));
        end
        repeat (3) @(negedge clk);
        grab(3, 7);
        for (int i = 3; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== exp_seg(newv, i)) begin
                failures++;
                $display("FAIL settle_frame slot%0d seg=%h expected %h", i, seg_cap[i], exp_seg(newv, i));
            end
        end
        btn_next = 1'b0;
        model_sel = (model_sel + 1) % 32;
        data_base = 32'h1000_0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_snapshot;
        bit ok;
        logic [31:0] oldv, newv;
        sync_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL snap_sync timeout got 0 expected 1");
        end
        oldv = data_base + 32'(model_sel);
        grab(0, 2);
        data_base = $urandom;
        newv = data_base + 32'(model_sel);
        grab(3, 7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== exp_seg(oldv, i)) begin
                failures++;
                $display("FAIL snap_hold slot%0d seg=%h expected %h", i, seg_cap[i], exp_seg(oldv, i));
            end
        end
        grab(0, 7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (an_cap[i] !== exp_an(i) || seg_cap[i] !== exp_seg(newv, i)) begin
                failures++;
                $display("FAIL snap_new slot%0d an=%h seg=%h expected %h %h", i, an_cap[i], seg_cap[i],
                         exp_an(i), exp_seg(newv, i));
            end
        end
        data_base = 32'h1000_0000;
    endtask

    task automatic test_reset_mid;
        while (model_sel != 5) begin
            do_press();
            model_sel = (model_sel + 1) % 32;
        end
        checks++;
        if (bus.reg_sel !== 5'd5) begin
            failures++;
            $display("FAIL mid_setup sel=%0d expected 5", bus.reg_sel);
        end
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'd0 || bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
                failures++;
                $display("FAIL mid_reset sel=%0d an=%h seg=%h expected 0 FF FF", bus.reg_sel, bus.an, bus.seg);
            end
        end
        rst = 1'b0;
        model_sel = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'd0) begin
                failures++;
                $display("FAIL held_no_step k=%0d sel=%0d expected 0", k, bus.reg_sel);
            end
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        btn_next = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (bus.reg_sel !== 5'((k >= PRESS_LAT) ? 1 : 0)) begin
                failures++;
                $display("FAIL repress k=%0d sel=%0d expected %0d", k, bus.reg_sel, (k >= PRESS_LAT) ? 1 : 0);
            end
        end
        btn_next = 1'b0;
        model_sel = 1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        test_reset();
        test_debounce();
        test_wrap();
        test_auto();
        test_sel_settle();
        test_snapshot();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog sim_time=%0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
